// File: rtl/nios_led_sequencer_if.sv
// Avalon-MM slave bus bundle between the Nios interconnect and the LED sequencer.
interface nios_led_sequencer_if;
   logic [1:0]  address;
   logic        chipselect;
   logic        write_n;
   logic [31:0] writedata;
   logic [31:0] readdata;

   modport master (
      output address, chipselect, write_n, writedata,
      input  readdata
   );

   modport slave (
      input  address, chipselect, write_n, writedata,
      output readdata
   );
endinterface

// File: rtl/nios_led_sequencer.sv
// LED sequencer: a plain 8-bit output register while disabled; when enabled it
// steps the LEDs through static, blink or rotate patterns at a programmable
// tick rate, optionally stopping after a fixed number of steps.
module nios_led_sequencer #(
   parameter int unsigned          PERIOD_W       = 24,
   parameter logic [PERIOD_W-1:0]  DEFAULT_PERIOD = 24'd4999999
) (
   input  logic                     clk,
   input  logic                     reset_n,
   nios_led_sequencer_if.slave      bus,
   output logic [7:0]               out_port
);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RUN,
      ST_DONE
   } state_e;

   typedef enum logic [1:0] {
      MODE_STATIC,
      MODE_BLINK,
      MODE_ROL,
      MODE_ROR
   } mode_e;

   typedef enum logic [1:0] {
      REG_CTRL,
      REG_PATTERN,
      REG_PERIOD,
      REG_STATUS
   } reg_e;

   state_e              state_q,   state_d;
   logic                en_q,      en_d;
   mode_e               mode_q,    mode_d;
   logic                oneshot_q, oneshot_d;
   logic [7:0]          steps_q,   steps_d;
   logic [7:0]          pattern_q, pattern_d;
   logic [PERIOD_W-1:0] period_q,  period_d;
   logic [PERIOD_W-1:0] cnt_q,     cnt_d;
   logic [7:0]          shreg_q,   shreg_d;
   logic                phase_q,   phase_d;
   // Nine bits so a programmed step count of 0 can be held as 256.
   logic [8:0]          stepcnt_q, stepcnt_d;
   logic                done_q,    done_d;
   logic [7:0]          out_q,     out_d;

   logic                wr;
   logic                tick;
   logic                unused_wdata;

   assign wr           = bus.chipselect && !bus.write_n;
   assign tick         = (state_q == ST_RUN) && (cnt_q == '0);
   assign out_port     = out_q;
   assign unused_wdata = ^bus.writedata[31:16];

   // Next-state logic: tick effects first, then any CPU write overrides what it touches.
   always_comb begin
      // NOTE: every variable gets its hold value first so no path can infer a latch.
      state_d   = state_q;
      en_d      = en_q;
      mode_d    = mode_q;
      oneshot_d = oneshot_q;
      steps_d   = steps_q;
      pattern_d = pattern_q;
      period_d  = period_q;
      cnt_d     = cnt_q;
      shreg_d   = shreg_q;
      phase_d   = phase_q;
      stepcnt_d = stepcnt_q;
      done_d    = done_q;

      if (state_q == ST_RUN) begin
         if (tick) begin
            cnt_d = period_q;
            case (mode_q)
               MODE_BLINK: phase_d = ~phase_q;
               MODE_ROL:   shreg_d = {shreg_q[6:0], shreg_q[7]};
               MODE_ROR:   shreg_d = {shreg_q[0], shreg_q[7:1]};
               default:    shreg_d = shreg_q;
            endcase
            if (oneshot_q) begin
               stepcnt_d = stepcnt_q - 9'd1;
               if (stepcnt_q == 9'd1) begin
                  state_d = ST_DONE;
                  done_d  = 1'b1;
               end
            end
         end else begin
            cnt_d = cnt_q - PERIOD_W'(1);
         end
      end

      if (wr) begin
         case (bus.address)
            REG_CTRL: begin
               en_d      = bus.writedata[0];
               mode_d    = mode_e'(bus.writedata[2:1]);
               oneshot_d = bus.writedata[3];
               steps_d   = bus.writedata[15:8];
               if (bus.writedata[0]) begin
                  // Restart from any state; this also discards a same-cycle tick.
                  state_d   = ST_RUN;
                  shreg_d   = pattern_q;
                  cnt_d     = period_q;
                  phase_d   = 1'b1;
                  stepcnt_d = (bus.writedata[15:8] == 8'd0) ? 9'd256
                                                            : {1'b0, bus.writedata[15:8]};
                  done_d    = 1'b0;
               end else begin
                  state_d = ST_IDLE;
               end
            end
            REG_PATTERN: begin
               pattern_d = bus.writedata[7:0];
               if (state_q == ST_RUN) begin
                  shreg_d = bus.writedata[7:0];
               end
            end
            REG_PERIOD: begin
               period_d = bus.writedata[PERIOD_W-1:0];
            end
            default: begin
               if (bus.writedata[1]) begin
                  done_d = 1'b0;
               end
            end
         endcase
      end

      // LED drive: the raw pattern while idle, the working pattern otherwise.
      // DONE keeps showing the frozen shreg/phase, so the LEDs hold.
      if (state_q == ST_IDLE) begin
         out_d = pattern_q;
      end else if (mode_q == MODE_BLINK) begin
         out_d = shreg_q & {8{phase_q}};
      end else begin
         out_d = shreg_q;
      end
   end

   // Zero-wait-state register read mux.
   always_comb begin
      bus.readdata = '0;
      case (bus.address)
         REG_CTRL:    bus.readdata = {16'd0, steps_q, 4'd0, oneshot_q, mode_q, en_q};
         REG_PATTERN: bus.readdata = {24'd0, pattern_q};
         REG_PERIOD:  bus.readdata[PERIOD_W-1:0] = period_q;
         default:     bus.readdata = {16'd0, out_q, 6'd0, done_q, (state_q == ST_RUN)};
      endcase
   end

   // State and register update with synchronous active-low reset.
   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      if (!reset_n) begin
         state_q   <= ST_IDLE;
         en_q      <= 1'b0;
         mode_q    <= MODE_STATIC;
         oneshot_q <= 1'b0;
         steps_q   <= 8'd0;
         pattern_q <= 8'd0;
         period_q  <= DEFAULT_PERIOD;
         cnt_q     <= '0;
         shreg_q   <= 8'd0;
         phase_q   <= 1'b1;
         stepcnt_q <= 9'd0;
         done_q    <= 1'b0;
         out_q     <= 8'd0;
      end else begin
         state_q   <= state_d;
         en_q      <= en_d;
         mode_q    <= mode_d;
         oneshot_q <= oneshot_d;
         steps_q   <= steps_d;
         pattern_q <= pattern_d;
         period_q  <= period_d;
         cnt_q     <= cnt_d;
         shreg_q   <= shreg_d;
         phase_q   <= phase_d;
         stepcnt_q <= stepcnt_d;
         done_q    <= done_d;
         out_q     <= out_d;
      end
   end

endmodule

// File: tb/tb_nios_led_sequencer.sv
// Self-checking bench for nios_led_sequencer: directed scenarios plus a
// randomized run compared against a tick-counting reference model.
module tb_nios_led_sequencer;

   localparam int          PW  = 24;
   localparam logic [23:0] DEF = 24'd4999999;

   logic       clk = 1'b0;
   logic       reset_n;
   logic [7:0] out_port;

   nios_led_sequencer_if bus_if ();

   nios_led_sequencer #(
      .PERIOD_W       (PW),
      .DEFAULT_PERIOD (DEF)
   ) dut (
      .clk      (clk),
      .reset_n  (reset_n),
      .bus      (bus_if),
      .out_port (out_port)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=0x%08h expected=0x%08h at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference model: the working pattern is described as a base value plus a
   // net rotation count and a blink toggle count; ticks are scheduled by
   // absolute edge number.
   longint     m_edge = 0;
   longint     m_next = 0;
   bit         m_en, m_oneshot, m_done;
   bit [1:0]   m_mode;
   bit [7:0]   m_steps, m_pattern, m_base, m_out;
   bit [23:0]  m_period;
   int         m_rot, m_toggles, m_left;
   int         m_st;   // 0 idle, 1 running, 2 finished

   function automatic bit [7:0] rot_left(input bit [7:0] b, input int n);
      int        k;
      bit [15:0] w;
      k = ((n % 8) + 8) % 8;
      w = {b, b} << k;
      return w[15:8];
   endfunction

   function automatic bit [7:0] model_disp();
      bit [7:0] sh;
      if (m_st == 0) return m_pattern;
      sh = rot_left(m_base, m_rot);
      if (m_mode == 2'd1 && (m_toggles % 2) == 1) return 8'h00;
      return sh;
   endfunction

   function automatic logic [31:0] model_read(input logic [1:0] a);
      case (a)
         2'd0:    return {16'd0, m_steps, 4'd0, m_oneshot, m_mode, m_en};
         2'd1:    return {24'd0, m_pattern};
         2'd2:    return {8'd0, m_period};
         default: return {16'd0, m_out, 6'd0, m_done, (m_st == 1)};
      endcase
   endfunction

   task automatic model_edge(input bit rst, input bit wr, input logic [1:0] a, input logic [31:0] d);
      bit [7:0]  new_out;
      bit        pre_run;
      bit [23:0] old_period;
      m_edge++;
      if (rst) begin
         m_en = 0; m_oneshot = 0; m_done = 0; m_mode = 0; m_steps = 0;
         m_pattern = 0; m_base = 0; m_out = 0; m_period = DEF;
         m_rot = 0; m_toggles = 0; m_left = 0; m_st = 0;
         return;
      end
      new_out    = model_disp();
      pre_run    = (m_st == 1);
      old_period = m_period;
      if (pre_run && m_edge == m_next) begin
         m_next = m_edge + longint'(old_period) + 1;
         case (m_mode)
            2'd1:    m_toggles++;
            2'd2:    m_rot++;
            2'd3:    m_rot--;
            default: ;
         endcase
         if (m_oneshot) begin
            m_left--;
            if (m_left == 0) begin
               m_st   = 2;
               m_done = 1;
            end
         end
      end
      if (wr) begin
         case (a)
            2'd0: begin
               m_en      = d[0];
               m_mode    = d[2:1];
               m_oneshot = d[3];
               m_steps   = d[15:8];
               if (d[0]) begin
                  m_st      = 1;
                  m_base    = m_pattern;
                  m_rot     = 0;
                  m_toggles = 0;
                  m_left    = (d[15:8] == 8'd0) ? 256 : int'(d[15:8]);
                  m_next    = m_edge + longint'(old_period) + 1;
                  m_done    = 0;
               end else begin
                  m_st = 0;
               end
            end
            2'd1: begin
               m_pattern = d[7:0];
               if (pre_run) begin
                  m_base = d[7:0];
                  m_rot  = 0;
               end
            end
            2'd2:    m_period = d[23:0];
            default: if (d[1]) m_done = 0;
         endcase
      end
      m_out = new_out;
   endtask

   // One clock: drive inputs, check the read mux, take the edge, check the LEDs.
   task automatic step(input bit rst, input bit cs, input bit wn, input logic [1:0] a,
                       input logic [31:0] d);
      reset_n            = ~rst;
      bus_if.chipselect  = cs;
      bus_if.write_n     = wn;
      bus_if.address     = a;
      bus_if.writedata   = d;
      #1;
      check("readdata", bus_if.readdata, model_read(a));
      @(posedge clk);
      #1;
      model_edge(rst, cs && !wn, a, d);
      check("out_port", {24'd0, out_port}, {24'd0, m_out});
   endtask

   task automatic wr(input logic [1:0] a, input logic [31:0] d);
      step(1'b0, 1'b1, 1'b0, a, d);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b1, 2'd3, 32'hDEAD_BEEF);
   endtask

   task automatic rd_check(input string tag, input logic [1:0] a, input logic [31:0] exp);
      bus_if.address = a;
      #1;
      check(tag, bus_if.readdata, exp);
   endtask

   logic [7:0] blink_exp [6] = '{8'h0F, 8'h0F, 8'h00, 8'h00, 8'h0F, 8'h0F};
   logic [7:0] shot_exp  [5] = '{8'h01, 8'h80, 8'h40, 8'h20, 8'h20};

   initial begin
      logic [1:0]  ra;
      logic [31:0] rdat;
      int          r;
      bit          rcs, rwn;

      reset_n           = 1'b0;
      bus_if.chipselect = 1'b0;
      bus_if.write_n    = 1'b1;
      bus_if.address    = 2'd0;
      bus_if.writedata  = 32'd0;
      repeat (2) @(posedge clk);
      #1;
      model_edge(1'b1, 1'b0, 2'd0, 32'd0);

      // Reset state
      step(1'b1, 1'b0, 1'b1, 2'd0, 32'd0);
      check("rst_out", {24'd0, out_port}, 32'h0);
      rd_check("rst_period", 2'd2, {8'd0, DEF});
      rd_check("rst_ctrl", 2'd0, 32'h0);

      // Idle output register
      wr(2'd1, 32'h0000_00A5);
      check("idle_pat_1edge", {24'd0, out_port}, 32'h00);
      idle(1);
      check("idle_pat_2edge", {24'd0, out_port}, 32'hA5);
      rd_check("idle_status", 2'd3, 32'h0000_A500);

      // Rotate-left every 4 cycles
      wr(2'd2, 32'd3);
      wr(2'd1, 32'h81);
      wr(2'd0, 32'h0005);
      idle(1);
      check("rol_start", {24'd0, out_port}, 32'h81);
      idle(4);
      check("rol_step1", {24'd0, out_port}, 32'h03);
      idle(4);
      check("rol_step2", {24'd0, out_port}, 32'h06);
      rd_check("rol_status", 2'd3, 32'h0000_0601);

      // Blink every 2 cycles, then disable
      wr(2'd0, 32'h0);
      wr(2'd2, 32'd1);
      wr(2'd1, 32'h0F);
      wr(2'd0, 32'h0003);
      for (int i = 0; i < 6; i++) begin
         idle(1);
         check($sformatf("blink_%0d", i), {24'd0, out_port}, {24'd0, blink_exp[i]});
      end
      wr(2'd0, 32'h0);
      idle(1);
      check("blink_off", {24'd0, out_port}, 32'h0F);
      rd_check("blink_off_status", 2'd3, 32'h0000_0F00);

      // Oneshot rotate-right, 3 steps at one tick per cycle
      wr(2'd2, 32'd0);
      wr(2'd1, 32'h01);
      wr(2'd0, 32'h030F);
      for (int i = 0; i < 5; i++) begin
         idle(1);
         check($sformatf("shot_%0d", i), {24'd0, out_port}, {24'd0, shot_exp[i]});
      end
      rd_check("shot_done", 2'd3, 32'h0000_2002);
      wr(2'd3, 32'h2);
      rd_check("shot_clear", 2'd3, 32'h0000_2000);
      wr(2'd0, 32'h030F);
      idle(1);
      check("shot_restart", {24'd0, out_port}, 32'h01);
      rd_check("shot_restart_status", 2'd3, 32'h0000_0101);

      // Pattern write colliding with a rotate tick
      wr(2'd0, 32'h0);
      wr(2'd1, 32'h01);
      wr(2'd0, 32'h0005);
      idle(2);
      wr(2'd1, 32'hF0);
      idle(1);
      check("collide_pat", {24'd0, out_port}, 32'hF0);
      idle(1);
      check("collide_rot", {24'd0, out_port}, 32'hE1);

      // Reset in the middle of a run
      step(1'b1, 1'b0, 1'b1, 2'd0, 32'd0);
      check("midrst_out", {24'd0, out_port}, 32'h0);
      rd_check("midrst_period", 2'd2, {8'd0, DEF});
      rd_check("midrst_status", 2'd3, 32'h0);
      idle(2);
      check("midrst_after", {24'd0, out_port}, 32'h0);

      // Randomized traffic against the model
      for (int i = 0; i < 3000; i++) begin
         r    = int'($urandom_range(0, 99));
         ra   = 2'($urandom_range(0, 3));
         rdat = $urandom;
         if (r < 1) begin
            step(1'b1, 1'b0, 1'b1, ra, rdat);
         end else if (r < 30) begin
            case (ra)
               2'd0: begin
                  rdat[0]    = ($urandom_range(0, 9) < 7);
                  rdat[15:8] = 8'($urandom_range(0, 5));
               end
               2'd2:    rdat[23:0] = 24'($urandom_range(0, 3));
               default: ;
            endcase
            rcs = ($urandom_range(0, 7) != 0);
            rwn = ($urandom_range(0, 5) == 0);
            step(1'b0, rcs, rwn, ra, rdat);
         end else begin
            rwn = ($urandom_range(0, 1) == 1);
            step(1'b0, 1'b0, rwn, ra, rdat);
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
